// File: rtl/itcm_ctrl_pkg.sv
// itcm_ctrl_pkg: ITCM geometry shared by the fetch-side controller and its interface
package itcm_ctrl_pkg;
  localparam int ITCM_RAM_AW = 12;
  localparam int ITCM_RAM_DW = 32;
  localparam int INSTR_SIZE = ITCM_RAM_DW;
endpackage

// File: rtl/itcm_ctrl_if.sv
// itcm_ctrl_if: IFU fetch command/response channel between the fetch bridge and the ITCM
interface itcm_ctrl_if
  import itcm_ctrl_pkg::*;
#(
  parameter int AW = ITCM_RAM_AW,
  parameter int DW = ITCM_RAM_DW
);
  logic          itcm_cmd_valid;
  logic          itcm_cmd_ready;
  logic [AW-1:0] itcm_cmd_addr;
  logic          itcm_rsp_valid;
  logic          itcm_rsp_ready;
  logic [DW-1:0] itcm_rsp_rdata;
  modport master (
    output itcm_cmd_valid, itcm_cmd_addr, itcm_rsp_ready,
    input  itcm_cmd_ready, itcm_rsp_valid, itcm_rsp_rdata
  );
  modport slave (
    input  itcm_cmd_valid, itcm_cmd_addr, itcm_rsp_ready,
    output itcm_cmd_ready, itcm_rsp_valid, itcm_rsp_rdata
  );
endinterface

// File: rtl/itcm_rsp_hold.sv
// itcm_rsp_hold: single-entry valid/data holding register with load and clear
module itcm_rsp_hold #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic [DW-1:0] din,
  output logic          vld,
  output logic [DW-1:0] data
);
  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      data <= din;
    end else if (clear) begin
      vld  <= 1'b0;
    end
  end
endmodule

// File: rtl/itcm_ctrl.sv
// itcm_ctrl: read-only ITCM responder; 1-cycle SRAM read with a one-entry backpressure buffer
module itcm_ctrl
  import itcm_ctrl_pkg::*;
#(
  parameter int AW = ITCM_RAM_AW,
  parameter int DW = ITCM_RAM_DW
) (
  input  logic          clk,
  input  logic          rst,
  itcm_ctrl_if.slave    bus,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_dout
);
  logic          s1_vld;
  logic          hold_vld;
  logic [DW-1:0] hold_data;
  logic          accept;
  logic          pop;
  // rst gate keeps the SRAM idle while reset is held
  assign bus.itcm_cmd_ready = ~rst & ~hold_vld & (~s1_vld | bus.itcm_rsp_ready);
  assign accept = bus.itcm_cmd_valid & bus.itcm_cmd_ready;
  assign pop = bus.itcm_rsp_valid & bus.itcm_rsp_ready;
  assign ram_cs = accept;
  assign ram_we = 1'b0;
  assign ram_addr = bus.itcm_cmd_addr;
  assign bus.itcm_rsp_valid = hold_vld | s1_vld;
  assign bus.itcm_rsp_rdata = hold_vld ? hold_data : ram_dout;
  always_ff @(posedge clk) begin
    if (rst) s1_vld <= 1'b0;
    else s1_vld <= accept;
  end
  itcm_rsp_hold #(.DW(DW)) u_hold (
    .clk  (clk),
    .rst  (rst),
    .load (s1_vld & ~pop),
    .clear(hold_vld & pop),
    .din  (ram_dout),
    .vld  (hold_vld),
    .data (hold_data)
  );
endmodule
